dsss_sync_acquirer: RTL and testbench
=====================================

Name: dsss_sync_acquirer

Overview:
- Parametrised serial-search code acquisition and lock-tracking engine for the DSSS receive path.
- Correlates hard-decision IF samples against a locally generated m-sequence, one full code period per dwell, and slips local phase one sample per failed dwell.
- Declares sync after confirmation and drops it after consecutive misses.
- Successor to the fixed 31-chip, 16-sample/chip sync detection: code length, oversampling, threshold and hysteresis are all parameters.

Parameters:
- LFSR_W, 5, LFSR width; CODE_LEN = 2^LFSR_W-1 (31).
- TAPS, 5'b00101, Fibonacci feedback mask; feedback = XOR of (lfsr & TAPS), shifted in at MSB, lfsr shifts right; chip = lfsr[0].
- SPC, 16, samples per chip.
- CORR_THRESH, 400, minimum agreement count for a passing dwell (compare with >=).
- CONFIRM_N, 3, consecutive passing dwells required to lock.
- MISS_N, 4, consecutive failing dwells in LOCK before lock is lost.
- Derived: DWELL = CODE_LEN*SPC (496); PHASE_W = CORR_W = clog2(DWELL+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- en  in  1  engine enable; low forces IDLE
- seed  in  LFSR_W  local m-sequence initial state; sampled only on IDLE->SEARCH
- sample_valid  in  1  qualifies sample_in
- sample_in  in  1  hard-decision chip sample
- sync_flag  out  1  high while in LOCK
- state  out  2  0 IDLE, 1 SEARCH, 2 VERIFY, 3 LOCK
- code_phase  out  PHASE_W  accumulated local slip, mod DWELL
- corr_value  out  CORR_W  agreement count of the last completed dwell
- dwell_done  out  1  one-cycle pulse at each dwell completion
- lock_lost  out  1  one-cycle pulse on LOCK->SEARCH

Behaviour:
- Reset value of every output is 0; state is IDLE.
- Per-dwell timing:
  - Only valid cycles advance anything.
  - The sample counter runs 0..SPC-1; on wrap the LFSR steps.
  - The dwell counter runs 0..DWELL-1.
  - The accumulator adds 1 when sample_in == chip.
- Dwell end (valid sample at count DWELL-1) registers the outputs on the next edge:
  - corr_value = final accumulator.
  - dwell_done pulses.
  - The accumulator clears.
  - The pass/fail decision applies.
- Seed handling: IDLE with en=1 moves to SEARCH and loads seed; seed==0 is replaced by all-ones. Phase, accumulator and counters are zeroed.
- SEARCH:
  - pass -> VERIFY, confirm=1; if CONFIRM_N==1, go directly to LOCK.
  - fail -> slip: the local generator holds for the first valid sample of the next dwell; code_phase increments, wrapping DWELL-1 -> 0.
- VERIFY:
  - pass -> confirm+1; when confirm reaches CONFIRM_N -> LOCK.
  - fail -> SEARCH with slip applied.
- LOCK:
  - sync_flag=1.
  - pass clears the miss counter; fail increments it.
  - At MISS_N -> SEARCH with slip; sync_flag=0 and lock_lost pulses on the same edge.
- sync_flag rises on the edge after the last valid sample of the confirming dwell.
- en deasserted at any time -> IDLE next edge:
  - Outputs go to 0 except corr_value, which holds.
  - en low takes priority over a simultaneous dwell end.
- Asynchronous reset mid-dwell clears everything immediately; no pulse is emitted.
- sample_valid low mid-dwell stalls all counters; there is no timeout.
- Agreement at an intra-chip offset of k samples is 496-16k for the defaults, so the default threshold tolerates |k|<=6.

Optional Feature:
- Macro SYNC_STATS_EN.
- When defined, adds outputs acq_count[15:0] (LOCK entries) and loss_count[15:0] (lock_lost pulses). Both are saturating, cleared by reset, and not cleared by en.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package dsss_pkg holds:
  - state enum (IDLE/SEARCH/VERIFY/LOCK);
  - default LFSR_W, TAPS, SPC;
  - CODE_LEN/DWELL helper functions;
  - clog2.
- One sub-module, mseq_gen: LFSR plus sample-per-chip counter with load, hold (slip) and advance inputs. The transmitter's code source reuses it.

Test Plan:
- seed=5'b00001; input = local code, aligned; continuous valid -> corr_value=496 each dwell; sync_flag rises one cycle after valid sample #1488; code_phase=0.
- Same stream delayed 40 samples -> dwells fail through phase 33; first pass at code_phase=34 with corr_value=400; lock after 3 more dwells total from pass.
- sample_in constant 0 -> never leaves SEARCH/VERIFY; code_phase wraps 495->0 after 496 failed dwells.
- Locked, then input inverted for 4 dwells -> corr_value=0 each; lock_lost pulses once at 4th dwell end; sync_flag=0; state=SEARCH. Restoring the input after 3 inverted dwells keeps the lock.
- Async reset mid-VERIFY -> all outputs 0 immediately. en low at the dwell-end cycle -> IDLE; no state advance.
- seed=0 -> behaves identically to seed=5'b11111. With SYNC_STATS_EN: acq_count=1 and loss_count=1 after the scenario 4 sequence.

Source files
------------

// File: rtl/dsss_pkg.sv
// dsss_pkg: shared types, default code parameters and sizing helpers for the
// DSSS acquisition path (receiver acquirer and transmitter code source).
package dsss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCK   = 2'd3
  } acq_state_t;

  localparam int         DEF_LFSR_W = 5;
  localparam logic [4:0] DEF_TAPS   = 5'b00101;
  localparam int         DEF_SPC    = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int code_len(input int lfsr_w);
    return (1 << lfsr_w) - 1;
  endfunction

  function automatic int dwell_len(input int lfsr_w, input int spc);
    return code_len(lfsr_w) * spc;
  endfunction

endpackage

// File: rtl/dsss_sync_acquirer_if.sv
// dsss_sync_acquirer_if: hard-decision sample stream into the acquirer.
interface dsss_sync_acquirer_if;
  logic sample_valid;
  logic sample_in;

  modport master (output sample_valid, output sample_in);
  modport slave  (input  sample_valid, input  sample_in);
endinterface

// File: rtl/mseq_gen.sv
// mseq_gen: Fibonacci m-sequence generator with a samples-per-chip counter.
// load restarts from seed (zero seed replaced by all-ones), advance moves one
// sample forward, hold freezes the generator for that sample (phase slip).
module mseq_gen
  import dsss_pkg::*;
#(
  parameter int                LFSR_W = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEF_TAPS),
  parameter int                SPC    = DEF_SPC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  input  logic              hold,
  output logic              chip
);

  localparam int SPC_W = (SPC > 1) ? clog2(SPC) : 1;

  logic [LFSR_W-1:0] lfsr;
  logic [SPC_W-1:0]  spc_cnt;
  logic              feedback;
  logic              spc_wrap;

  assign feedback = ^(lfsr & TAPS);
  assign spc_wrap = (spc_cnt == SPC_W'(SPC - 1));
  assign chip     = lfsr[0];

  // Seed load, otherwise step the chip once per SPC unheld samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr    <= '0;
      spc_cnt <= '0;
    end else if (load) begin
      lfsr    <= (seed == '0) ? '1 : seed;
      spc_cnt <= '0;
    end else if (advance && !hold) begin
      if (spc_wrap) begin
        spc_cnt <= '0;
        lfsr    <= {feedback, lfsr[LFSR_W-1:1]};
      end else begin
        spc_cnt <= spc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsss_sync_acquirer.sv
// dsss_sync_acquirer: serial-search code acquisition and lock tracking.
// One full code period is correlated per dwell; a failed search dwell slips
// the local code by one sample. Build macro SYNC_STATS_EN adds saturating
// acq_count / loss_count statistics outputs.
//
//   state  | meaning
//   IDLE   | engine disabled, outputs cleared (corr_value holds)
//   SEARCH | dwelling at code_phase, slipping one sample per failed dwell
//   VERIFY | candidate phase found, counting consecutive passing dwells
//   LOCK   | sync declared, counting consecutive misses
module dsss_sync_acquirer
  import dsss_pkg::*;
#(
  parameter int                LFSR_W      = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS        = LFSR_W'(DEF_TAPS),
  parameter int                SPC         = DEF_SPC,
  parameter int                CORR_THRESH = 400,
  parameter int                CONFIRM_N   = 3,
  parameter int                MISS_N      = 4,
  localparam int               DWELL       = dwell_len(LFSR_W, SPC),
  localparam int               PHASE_W     = clog2(DWELL + 1),
  localparam int               CORR_W      = PHASE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [LFSR_W-1:0]   seed,
  dsss_sync_acquirer_if.slave smp,
  output logic                sync_flag,
  output logic [1:0]          state,
  output logic [PHASE_W-1:0]  code_phase,
  output logic [CORR_W-1:0]   corr_value,
  output logic                dwell_done,
  output logic                lock_lost
`ifdef SYNC_STATS_EN
  ,
  output logic [15:0]         acq_count,
  output logic [15:0]         loss_count
`endif
);

  localparam int CNF_W  = (CONFIRM_N > 1) ? clog2(CONFIRM_N + 1) : 1;
  localparam int MISS_W = (MISS_N > 1) ? clog2(MISS_N + 1) : 1;

  acq_state_t         state_q, state_d;
  logic [PHASE_W-1:0] dwell_q, dwell_d;
  logic [CORR_W-1:0]  acc_q, acc_d, acc_final;
  logic [PHASE_W-1:0] phase_q, phase_d, phase_inc;
  logic [CORR_W-1:0]  corr_q, corr_d;
  logic               done_q, done_d;
  logic               lost_q, lost_d;
  logic [CNF_W-1:0]   confirm_q, confirm_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               slip_q, slip_d;
  logic               load_gen, adv_gen, hold_gen;
  logic               chip, pass;

  mseq_gen #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SPC    (SPC)
  ) u_mseq (
    .clk     (clk),
    .reset   (reset),
    .load    (load_gen),
    .seed    (seed),
    .advance (adv_gen),
    .hold    (hold_gen),
    .chip    (chip)
  );

  assign acc_final = acc_q + CORR_W'(smp.sample_in == chip);
  assign pass      = (int'(acc_final) >= CORR_THRESH);
  assign phase_inc = (phase_q == PHASE_W'(DWELL - 1)) ? '0 : phase_q + 1'b1;

  // Next-state, dwell bookkeeping and pass/fail decision at dwell end.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    acc_d     = acc_q;
    phase_d   = phase_q;
    corr_d    = corr_q;
    done_d    = 1'b0;
    lost_d    = 1'b0;
    confirm_d = confirm_q;
    miss_d    = miss_q;
    slip_d    = slip_q;
    load_gen  = 1'b0;
    adv_gen   = 1'b0;
    hold_gen  = 1'b0;

    if (!en || state_q == ST_IDLE) begin
      // Disabling wins over any dwell end; enabling from IDLE loads the seed.
      state_d   = en ? ST_SEARCH : ST_IDLE;
      load_gen  = en;
      dwell_d   = '0;
      acc_d     = '0;
      phase_d   = '0;
      confirm_d = '0;
      miss_d    = '0;
      slip_d    = 1'b0;
    end else if (smp.sample_valid) begin
      adv_gen  = 1'b1;
      hold_gen = slip_q;
      slip_d   = 1'b0;
      if (dwell_q == PHASE_W'(DWELL - 1)) begin
        dwell_d = '0;
        acc_d   = '0;
        corr_d  = acc_final;
        done_d  = 1'b1;
        case (state_q)
          ST_SEARCH: begin
            if (pass) begin
              confirm_d = CNF_W'(1);
              miss_d    = '0;
              state_d   = (CONFIRM_N <= 1) ? ST_LOCK : ST_VERIFY;
            end else begin
              phase_d = phase_inc;
              slip_d  = 1'b1;
            end
          end
          ST_VERIFY: begin
            if (pass) begin
              confirm_d = confirm_q + 1'b1;
              if (int'(confirm_q) + 1 >= CONFIRM_N) begin
                state_d = ST_LOCK;
                miss_d  = '0;
              end
            end else begin
              state_d   = ST_SEARCH;
              confirm_d = '0;
              phase_d   = phase_inc;
              slip_d    = 1'b1;
            end
          end
          ST_LOCK: begin
            if (pass) begin
              miss_d = '0;
            end else if (int'(miss_q) + 1 >= MISS_N) begin
              state_d   = ST_SEARCH;
              miss_d    = '0;
              confirm_d = '0;
              lost_d    = 1'b1;
              phase_d   = phase_inc;
              slip_d    = 1'b1;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        dwell_d = dwell_q + 1'b1;
        acc_d   = acc_final;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dwell_q   <= '0;
      acc_q     <= '0;
      phase_q   <= '0;
      corr_q    <= '0;
      done_q    <= 1'b0;
      lost_q    <= 1'b0;
      confirm_q <= '0;
      miss_q    <= '0;
      slip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      acc_q     <= acc_d;
      phase_q   <= phase_d;
      corr_q    <= corr_d;
      done_q    <= done_d;
      lost_q    <= lost_d;
      confirm_q <= confirm_d;
      miss_q    <= miss_d;
      slip_q    <= slip_d;
    end
  end

  assign sync_flag  = (state_q == ST_LOCK);
  assign state      = state_q;
  assign code_phase = phase_q;
  assign corr_value = corr_q;
  assign dwell_done = done_q;
  assign lock_lost  = lost_q;

`ifdef SYNC_STATS_EN
  // Saturating lifetime statistics; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acq_count  <= '0;
      loss_count <= '0;
    end else begin
      if (state_d == ST_LOCK && state_q != ST_LOCK && acq_count != 16'hFFFF)
        acq_count <= acq_count + 16'd1;
      if (lost_d && loss_count != 16'hFFFF)
        loss_count <= loss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dsss_sync_acquirer.sv
// tb_dsss_sync_acquirer: directed bench for dsss_sync_acquirer. A default
// instance covers acquisition, lock, loss, reset and enable behaviour; a
// small 7-chip, 2-sample/chip instance covers code_phase wrap-around.
module tb_dsss_sync_acquirer;
  import dsss_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  seed;
  logic        sync_flag;
  logic [1:0]  state;
  logic [8:0]  code_phase;
  logic [8:0]  corr_value;
  logic        dwell_done;
  logic        lock_lost;

  logic        en_s;
  logic [2:0]  seed_s;
  logic        sync_flag_s;
  logic [1:0]  state_s;
  logic [3:0]  code_phase_s;
  logic [3:0]  corr_value_s;
  logic        dwell_done_s;
  logic        lock_lost_s;

`ifdef SYNC_STATS_EN
  logic [15:0] acq_count, loss_count, acq_count_s, loss_count_s;
`endif

  dsss_sync_acquirer_if smp ();
  dsss_sync_acquirer_if smp_s ();

  dsss_sync_acquirer dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .seed       (seed),
    .smp        (smp),
    .sync_flag  (sync_flag),
    .state      (state),
    .code_phase (code_phase),
    .corr_value (corr_value),
    .dwell_done (dwell_done),
    .lock_lost  (lock_lost)
`ifdef SYNC_STATS_EN
    ,
    .acq_count  (acq_count),
    .loss_count (loss_count)
`endif
  );

  dsss_sync_acquirer #(
    .LFSR_W      (3),
    .TAPS        (3'b011),
    .SPC         (2),
    .CORR_THRESH (12),
    .CONFIRM_N   (3),
    .MISS_N      (4)
  ) dut_s (
    .clk        (clk),
    .reset      (reset),
    .en         (en_s),
    .seed       (seed_s),
    .smp        (smp_s),
    .sync_flag  (sync_flag_s),
    .state      (state_s),
    .code_phase (code_phase_s),
    .corr_value (corr_value_s),
    .dwell_done (dwell_done_s),
    .lock_lost  (lock_lost_s)
`ifdef SYNC_STATS_EN
    ,
    .acq_count  (acq_count_s),
    .loss_count (loss_count_s)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference chip tables: 0 = seed 5'b00001, 1 = seed 5'b11111.
  bit code_tab [2][31];
  int sidx;
  int kc;
  int dly;
  bit inv;
  bit zero_mode;

  task automatic fill_code(input int k, input logic [4:0] s);
    logic [4:0] l;
    logic       fb;
    l = s;
    for (int i = 0; i < 31; i++) begin
      code_tab[k][i] = l[0];
      fb = ^(l & 5'b00101);
      l  = {fb, l[4:1]};
    end
  endtask

  // Feed n valid samples of the reference stream; outputs sampled #1 after edge.
  task automatic feed(input int n);
    int pos;
    for (int i = 0; i < n; i++) begin
      pos = (((sidx - dly) % 496) + 496) % 496;
      smp.sample_valid = 1'b1;
      smp.sample_in    = zero_mode ? 1'b0 : (code_tab[kc][pos / 16] ^ inv);
      @(posedge clk);
      #1;
      sidx++;
    end
  endtask

  task automatic start(input logic [4:0] s, input int k, input int d);
    smp.sample_valid = 1'b0;
    seed = s;
    en   = 1'b1;
    @(posedge clk);
    #1;
    kc = k; dly = d; inv = 1'b0; zero_mode = 1'b0; sidx = 0;
  endtask

  task automatic stop();
    smp.sample_valid = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; seed = '0;
    smp.sample_valid = 1'b0; smp.sample_in = 1'b0;
    en_s = 1'b0; seed_s = '0;
    smp_s.sample_valid = 1'b0; smp_s.sample_in = 1'b0;
    kc = 0; dly = 0; inv = 1'b0; zero_mode = 1'b0; sidx = 0;
    fill_code(0, 5'b00001);
    fill_code(1, 5'b11111);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_sync", sync_flag, 0);
    chk("rst_phase", code_phase, 0);
    chk("rst_corr", corr_value, 0);
    chk("rst_done", dwell_done, 0);
    chk("rst_lost", lock_lost, 0);
    reset = 1'b0;

    // Aligned acquisition with seed 1.
    start(5'b00001, 0, 0);
    chk("start_state", state, 1);
    feed(496);
    chk("al_d0_done", dwell_done, 1);
    chk("al_d0_corr", corr_value, 496);
    chk("al_d0_state", state, 2);
    feed(1);
    chk("al_done_pulse", dwell_done, 0);
    feed(495);
    chk("al_d1_state", state, 2);
    chk("al_d1_corr", corr_value, 496);
    feed(495);
    chk("al_sync_pre", sync_flag, 0);
    feed(1);
    chk("al_sync_rise", sync_flag, 1);
    chk("al_lock_state", state, 3);
    chk("al_lock_phase", code_phase, 0);

    // Three misses then recovery keeps the lock.
    inv = 1'b1;
    for (int d = 0; d < 3; d++) begin
      feed(496);
      chk("miss3_corr", corr_value, 0);
      chk("miss3_sync", sync_flag, 1);
    end
    inv = 1'b0;
    feed(496);
    chk("recover_corr", corr_value, 496);
    chk("recover_sync", sync_flag, 1);

    // Four misses drop the lock.
    inv = 1'b1;
    for (int d = 0; d < 3; d++) begin
      feed(496);
      chk("miss4_lost_early", lock_lost, 0);
    end
    feed(496);
    chk("miss4_corr", corr_value, 0);
    chk("miss4_lost", lock_lost, 1);
    chk("miss4_sync", sync_flag, 0);
    chk("miss4_state", state, 1);
    chk("miss4_phase", code_phase, 1);
    feed(1);
    chk("miss4_lost_pulse", lock_lost, 0);
`ifdef SYNC_STATS_EN
    chk("acq_count", acq_count, 1);
    chk("loss_count", loss_count, 1);
`endif
    stop();
    chk("stop_state", state, 0);
    chk("stop_phase", code_phase, 0);

    // Stream delayed by 40 samples: first pass at phase 34 (offset 6).
    start(5'b00001, 0, 40);
    for (int d = 0; d < 34; d++) begin
      feed(496);
      chk("dly_search_state", state, 1);
      chk("dly_search_phase", code_phase, d + 1);
    end
    feed(496);
    chk("dly_pass_corr", corr_value, 400);
    chk("dly_pass_state", state, 2);
    chk("dly_pass_phase", code_phase, 34);
    feed(496);
    chk("dly_v2_state", state, 2);
    chk("dly_v2_corr", corr_value, 400);
    feed(496);
    chk("dly_lock_state", state, 3);
    chk("dly_lock_sync", sync_flag, 1);
    chk("dly_lock_phase", code_phase, 34);
    stop();

    // Constant zero input never passes.
    start(5'b00001, 0, 0);
    zero_mode = 1'b1;
    feed(496);
    chk("zero_corr", corr_value, 240);
    chk("zero_state", state, 1);
    chk("zero_phase1", code_phase, 1);
    feed(496);
    chk("zero_state2", state, 1);
    chk("zero_phase2", code_phase, 2);
    stop();

    // Asynchronous reset mid-VERIFY.
    start(5'b00001, 0, 0);
    feed(496);
    chk("arst_pre_state", state, 2);
    feed(100);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_corr", corr_value, 0);
    chk("arst_sync", sync_flag, 0);
    chk("arst_done", dwell_done, 0);
    reset = 1'b0;
    smp.sample_valid = 1'b0;
    en = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_after_done", dwell_done, 0);

    // en low on the dwell-end cycle wins over the dwell decision.
    start(5'b00001, 0, 0);
    feed(496);
    chk("enlo_pre_corr", corr_value, 496);
    inv = 1'b1;
    feed(495);
    en = 1'b0;
    feed(1);
    chk("enlo_state", state, 0);
    chk("enlo_done", dwell_done, 0);
    chk("enlo_corr_hold", corr_value, 496);
    chk("enlo_phase", code_phase, 0);
    smp.sample_valid = 1'b0;

    // Zero seed behaves as all-ones.
    start(5'b00000, 1, 0);
    feed(496);
    chk("seed0_corr", corr_value, 496);
    chk("seed0_state", state, 2);
    stop();

    // Small instance: phase wraps DWELL-1 -> 0 after DWELL failed dwells.
    seed_s = 3'b001;
    en_s = 1'b1;
    @(posedge clk);
    #1;
    chk("s_start_state", state_s, 1);
    smp_s.sample_valid = 1'b1;
    smp_s.sample_in    = 1'b0;
    for (int d = 0; d < 14; d++) begin
      repeat (14) @(posedge clk);
      #1;
      if (d == 0) chk("s_zero_corr", corr_value_s, 6);
      if (d == 12) chk("s_phase_13", code_phase_s, 13);
      if (d == 13) begin
        chk("s_phase_wrap", code_phase_s, 0);
        chk("s_wrap_state", state_s, 1);
      end
    end
    smp_s.sample_valid = 1'b0;
    en_s = 1'b0;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
